bcd_serial_add_ctrl: RTL and testbench

Sequencer that performs multi-digit packed-BCD addition by time-sharing a single one-digit BCD adder datapath, one digit per clock, least-significant digit first. It captures the operands on a start handshake, walks a digit index, and registers the inter-digit carry. It writes each digit result into a result register and reports completion with a one-cycle done pulse. It sits between a requesting control unit and the team's one-digit BCD adder instance.

---
 rtl/bcd_serial_add_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Multi-digit packed-BCD adder that reuses one single-digit BCD adder
//   datapath, processing one digit per clock, least-significant digit first.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - operation request, accepted only while ready=1
//   A, B   - packed BCD addends, digit 0 in bits [3:0]
//   Cin    - carry into digit 0
//   ready  - idle, next start will be accepted
//   busy   - digit steps in progress
//   done   - one-cycle completion pulse
//   S      - packed BCD sum, stable from done until the next accepted start
//   C      - carry out of the most-significant digit
//   err    - a captured operand digit was not valid BCD (>9)
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] S,
  output logic                C,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   idx_reg, idx_next;
  logic              carry_reg, carry_next;
  logic [W-1:0]      a_reg, a_next;
  logic [W-1:0]      b_reg, b_next;
  logic [W-1:0]      s_reg, s_next;
  logic              c_reg, c_next;
  logic              err_reg, err_next;

  // Per-digit validity check on the live inputs; only consulted on the
  // accepting edge, so it reflects exactly the operands being captured.
  logic [DIGITS-1:0] bad_a, bad_b;
  logic              op_invalid;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
    assign bad_a[gi] = (A[4*gi +: 4] > 4'd9);
    assign bad_b[gi] = (B[4*gi +: 4] > 4'd9);
  end

  assign op_invalid = (|bad_a) | (|bad_b);

  // One-digit BCD adder datapath operating on the currently indexed digit.
  logic [3:0] a_cur, b_cur;
  logic [4:0] sum_raw, sum_adj;
  logic [3:0] dig;
  logic       carry_out;
  logic       last_digit;

  always_comb begin
    a_cur = 4'd0;
    b_cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDXW'(i)) begin
        a_cur = a_reg[4*i +: 4];
        b_cur = b_reg[4*i +: 4];
      end
    end
    sum_raw = {1'b0, a_cur} + {1'b0, b_cur} + {4'd0, carry_reg};
    sum_adj = sum_raw + 5'd6;
    if (sum_raw > 5'd9) begin
      // Decimal correction: adding 6 skips the six unused 4-bit codes.
      dig       = sum_adj[3:0];
      carry_out = 1'b1;
    end else begin
      dig       = sum_raw[3:0];
      carry_out = 1'b0;
    end
  end

  assign last_digit = (idx_reg == IDXW'(DIGITS - 1));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    c_next     = c_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next   = A;
          b_next   = B;
          s_next   = '0;
          err_next = 1'b0;
          idx_next = '0;
          if (op_invalid) begin
            err_next   = 1'b1;
            c_next     = 1'b0;
            state_next = FIN;
          end else begin
            carry_next = Cin;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_reg == IDXW'(i)) begin
            s_next[4*i +: 4] = dig;
          end
        end
        carry_next = carry_out;
        if (last_digit) begin
          // Index parks on the last digit rather than wrapping.
          c_next     = carry_out;
          state_next = FIN;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      c_reg     <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      s_reg     <= s_next;
      c_reg     <= c_next;
      err_reg   <= err_next;
    end
  end

  // Status flags decode directly from the state, so they are mutually
  // exclusive by construction and respond to reset immediately.
  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == FIN);
  assign S     = s_reg;
  assign C     = c_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Testbench for bcd_serial_add_ctrl: directed and randomized operations,
// decimal-arithmetic reference model, queue-based scoreboard.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int IDXW   = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         ready, busy, done;
  logic [W-1:0] S;
  logic         C, err;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .ready(ready), .busy(busy), .done(done), .S(S), .C(C), .err(err)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         e;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   negcnt = 0;
  int   blk = 0;
  int   hold_mode = 0;
  int   prev_acc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand values.
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t   r;
    longint lim = 1;
    longint sum;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    r.acc = 0;
    if (has_bad(a) || has_bad(b)) begin
      r.s = '0; r.c = 1'b0; r.e = 1'b1; r.lat = 1;
    end else begin
      sum = bcd2int(a) + bcd2int(b) + longint'(ci);
      r.s = int2bcd(sum % lim);
      r.c = (sum >= lim);
      r.e = 1'b0;
      r.lat = DIGITS + 1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0))
      r[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  // Monitor: tracks expected handshake timing, detects acceptances (pushing
  // the model's response), and pops/compares on each done pulse.
  always @(negedge clk) begin
    negcnt++;
    if (!rst_n) begin
      sb.delete();
      blk = 0;
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end else begin
      if (blk > 0) blk--;
      chk("ready", ready, blk == 0);
      chk("busy", busy, blk > 1);
      chk("done", done, blk == 1);
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          mon_e = sb.pop_front();
          chk("S", S, mon_e.s);
          chk("C", C, mon_e.c);
          chk("err", err, mon_e.e);
          chk("latency", negcnt - mon_e.acc, mon_e.lat);
        end
      end
      if (ready && start) begin
        mon_e = model(A, B, Cin);
        mon_e.acc = negcnt;
        sb.push_back(mon_e);
        blk = mon_e.lat + 1;
        $display("accept A=%h B=%h Cin=%0d -> exp S=%h C=%0d err=%0d", A, B, Cin, mon_e.s, mon_e.c, mon_e.e);
        if (hold_mode == 2) chk("spacing", negcnt - prev_acc, DIGITS + 2);
        if (hold_mode == 1) hold_mode = 2;
        prev_acc = negcnt;
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 100);
    if (!ready) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got ready=0 expected ready=1 within 100 cycles", tag);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the operation is over.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    A = a; B = b; Cin = ci; start = 1'b1;
    wait_ready("accept");
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    wait_ready("complete");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_S", S, 0);
    chk("reset_C", C, 0);
    chk("reset_err", err, 0);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    do_op(16'h1234, 16'h5678, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0);
    do_op(16'h9999, 16'h9999, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b0);
    do_op(16'h12A4, 16'h0001, 1'b0);
    do_op(16'h0042, 16'h0058, 1'b1);

    // start held high across several operations, operands changed mid-RUN
    hold_mode = 1;
    A = rand_bcd(0); B = rand_bcd(0); Cin = 1'($urandom); start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready("hold_accept");
      @(posedge clk); #1;
      if (k == 3) start = 1'b0;
      A = W'($urandom); B = W'($urandom);
      @(posedge clk); #1;
      A = rand_bcd(0); B = rand_bcd(0); Cin = 1'($urandom);
    end
    wait_ready("hold_complete");
    hold_mode = 0;
    @(posedge clk); #1;

    // Leave C=1 behind, then reset in the middle of a RUN
    do_op(16'h9999, 16'h0001, 1'b0);
    A = 16'h4321; B = 16'h1111; Cin = 1'b0; start = 1'b1;
    wait_ready("rst_accept");
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_S", S, 0);
    chk("midrst_C", C, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0505, 16'h0505, 1'b1);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      do_op(rand_bcd(1), rand_bcd(1), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
